// File: rtl/mdiv_pkg.sv
// Shared types and defaults for the iterative multiply/divide unit.
package mdiv_pkg;

    localparam int unsigned MDIV_XLEN = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } mdiv_op_t;

    typedef logic [1:0] mdiv_state_t;
    localparam mdiv_state_t ST_IDLE = 2'd0;
    localparam mdiv_state_t ST_RUN  = 2'd1;
    localparam mdiv_state_t ST_FIX  = 2'd2;

endpackage

// File: rtl/mdiv_if.sv
// Request/result bundle between the M stage and the multiply/divide unit.
interface mdiv_if
    import mdiv_pkg::*;
#(
    parameter int unsigned XLEN = MDIV_XLEN
) ();
    logic            START;
    mdiv_op_t        OP;
    logic [XLEN-1:0] SRC_A;
    logic [XLEN-1:0] SRC_B;
    logic            BUSY;
    logic [XLEN-1:0] HI;
    logic [XLEN-1:0] LO;

    modport master (output START, OP, SRC_A, SRC_B, input BUSY, HI, LO);
    modport slave  (input START, OP, SRC_A, SRC_B, output BUSY, HI, LO);
endinterface

// File: rtl/mdiv_step.sv
// One iteration of shift-add multiply or restoring divide on the 2*XLEN accumulator.
module mdiv_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   opb,
    output logic [2*XLEN-1:0] acc_out
);
    logic [XLEN:0] sum;
    logic [XLEN:0] trial;

    always_comb begin
        sum   = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, opb} : (XLEN+1)'(0));
        // The shifted remainder needs XLEN+1 bits; the bit above the remainder is acc MSB.
        trial = acc_in[2*XLEN-1:XLEN-1] - {1'b0, opb};
        if (is_div) begin
            if (trial[XLEN])
                acc_out = {acc_in[2*XLEN-2:0], 1'b0};
            else
                acc_out = {trial[XLEN-1:0], acc_in[XLEN-2:0], 1'b1};
        end else begin
            acc_out = {sum, acc_in[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/mdiv_unit.sv
// Iterative multiply/divide unit owning HI/LO; 32 iterations plus one sign-fixup cycle.
module mdiv_unit
    import mdiv_pkg::*;
#(
    parameter int unsigned XLEN = MDIV_XLEN
) (
    input logic   CLK,
    input logic   RESET_N,
    mdiv_if.slave bus
);
    localparam int unsigned CW = $clog2(XLEN);

    mdiv_state_t       state;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN-1:0]   opb;
    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;
    logic              is_div;
    logic              neg_q;
    logic              neg_r;

    logic              is_arith;
    logic              is_signed;
    logic              op_div;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;

    always_comb begin
        is_arith  = (bus.OP == MD_MULT) || (bus.OP == MD_MULTU) ||
                    (bus.OP == MD_DIV)  || (bus.OP == MD_DIVU);
        is_signed = (bus.OP == MD_MULT) || (bus.OP == MD_DIV);
        op_div    = (bus.OP == MD_DIV)  || (bus.OP == MD_DIVU);
        a_neg     = is_signed && bus.SRC_A[XLEN-1];
        b_neg     = is_signed && bus.SRC_B[XLEN-1];
        abs_a     = a_neg ? -bus.SRC_A : bus.SRC_A;
        abs_b     = b_neg ? -bus.SRC_B : bus.SRC_B;
        prod_fix  = neg_q ? -acc : acc;
        quo_fix   = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix   = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    end

    mdiv_step #(.XLEN(XLEN)) u_step (
        .is_div  (is_div),
        .acc_in  (acc),
        .opb     (opb),
        .acc_out (acc_next)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            hi     <= '0;
            lo     <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else if (bus.START && is_arith) begin
            // A new request always restarts from a fresh latch, aborting any in-flight op.
            state  <= ST_RUN;
            cnt    <= CW'(XLEN-1);
            is_div <= op_div;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            opb    <= op_div ? abs_b : abs_a;
            acc    <= {{XLEN{1'b0}}, (op_div ? abs_a : abs_b)};
        end else if (bus.START && bus.OP == MD_MTHI) begin
            hi    <= bus.SRC_A;
            state <= ST_IDLE;
        end else if (bus.START && bus.OP == MD_MTLO) begin
            lo    <= bus.SRC_A;
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_RUN: begin
                    acc <= acc_next;
                    if (cnt == '0)
                        state <= ST_FIX;
                    else
                        cnt <= cnt - 1'b1;
                end
                ST_FIX: begin
                    if (is_div) begin
                        lo <= quo_fix;
                        hi <= rem_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    state <= ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    assign bus.BUSY = (state != ST_IDLE);
    assign bus.HI   = hi;
    assign bus.LO   = lo;
endmodule

// File: tb/tb_mdiv_unit.sv
// Scoreboard bench for mdiv_unit: expected HI/LO queued at issue, compared when BUSY falls.
module tb_mdiv_unit;
    import mdiv_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    logic [31:0] arch_hi = '0;
    logic [31:0] arch_lo = '0;

    always #5 clk = ~clk;

    mdiv_if #(.XLEN(32)) bus ();

    mdiv_unit #(.XLEN(32)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t ref_model(input string tag, input mdiv_op_t op,
                                       input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint la, lb;
        logic [63:0] p;
        e.tag = tag;
        e.hi  = '0;
        e.lo  = '0;
        case (op)
            MD_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                {e.hi, e.lo} = p;
            end
            MD_MULT: begin
                la = longint'($signed(a));
                lb = longint'($signed(b));
                p  = 64'(la * lb);
                {e.hi, e.lo} = p;
            end
            MD_DIVU: begin
                if (b == 0) begin
                    e.lo = 32'hFFFF_FFFF;
                    e.hi = a;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
            MD_DIV: begin
                la = longint'($signed(a));
                lb = longint'($signed(b));
                if (b == 0) begin
                    e.lo = a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
                    e.hi = a;
                end else begin
                    e.lo = 32'(la / lb);
                    e.hi = 32'(la % lb);
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic start_op(input mdiv_op_t op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.START = 1'b1;
        bus.OP    = op;
        bus.SRC_A = a;
        bus.SRC_B = b;
        @(posedge clk);
        #1;
        bus.START = 1'b0;
    endtask

    task automatic issue(input string tag, input mdiv_op_t op,
                         input logic [31:0] a, input logic [31:0] b);
        exp_q.push_back(ref_model(tag, op, a, b));
        start_op(op, a, b);
    endtask

    task automatic push_const(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        exp_t e;
        e.tag = tag;
        e.hi  = hi;
        e.lo  = lo;
        exp_q.push_back(e);
    endtask

    // Counts BUSY samples since the sampling edge, then pops and compares the result.
    task automatic wait_done(input int exp_busy);
        int   n = 0;
        exp_t e;
        while (bus.BUSY && n < 200) begin
            if (n == 16) begin
                check("hold_hi", 64'(bus.HI), 64'(arch_hi));
                check("hold_lo", 64'(bus.LO), 64'(arch_lo));
            end
            n++;
            @(posedge clk);
            #1;
        end
        if (exp_q.size() == 0) begin
            check("sb_empty", 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            check({e.tag, "_busy"}, 64'(n), 64'(exp_busy));
            check({e.tag, "_hi"}, 64'(bus.HI), 64'(e.hi));
            check({e.tag, "_lo"}, 64'(bus.LO), 64'(e.lo));
            arch_hi = e.hi;
            arch_lo = e.lo;
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        mdiv_op_t    rop;
        bus.START = 1'b0;
        bus.OP    = MD_MULT;
        bus.SRC_A = '0;
        bus.SRC_B = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.BUSY), 64'd0);
        check("rst_hi", 64'(bus.HI), 64'd0);
        check("rst_lo", 64'(bus.LO), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        push_const("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
        start_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(33);

        push_const("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        start_op(MD_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done(33);

        push_const("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        start_op(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(33);

        push_const("divu_zero", 32'd100, 32'hFFFF_FFFF);
        start_op(MD_DIVU, 32'd100, 32'd0);
        wait_done(33);

        push_const("div_zero_neg", 32'hFFFF_FFF9, 32'h0000_0001);
        start_op(MD_DIV, 32'hFFFF_FFF9, 32'd0);
        wait_done(33);

        push_const("div_ovf", 32'd0, 32'h8000_0000);
        start_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(33);

        // Abort by a second mult/div: the first result must never appear.
        issue("multu_abort", MD_MULTU, 32'd5, 32'd6);
        repeat (9) @(posedge clk);
        exp_q.delete();
        push_const("divu_after_abort", 32'd2, 32'd14);
        start_op(MD_DIVU, 32'd100, 32'd7);
        wait_done(33);

        // MTLO mid-divide aborts it and writes LO only.
        issue("div_abort", MD_DIV, 32'd50, 32'd3);
        repeat (5) @(posedge clk);
        exp_q.delete();
        start_op(MD_MTLO, 32'h0000_1234, 32'd0);
        check("mtlo_busy", 64'(bus.BUSY), 64'd0);
        check("mtlo_lo", 64'(bus.LO), 64'h1234);
        check("mtlo_hi", 64'(bus.HI), 64'(arch_hi));
        arch_lo = 32'h0000_1234;
        repeat (40) @(posedge clk);
        #1;
        check("mtlo_stable", {bus.HI, bus.LO}, {arch_hi, arch_lo});

        start_op(MD_MTHI, 32'hCAFE_0001, 32'd0);
        check("mthi_busy", 64'(bus.BUSY), 64'd0);
        check("mthi_hi", 64'(bus.HI), 64'hCAFE_0001);
        arch_hi = 32'hCAFE_0001;

        start_op(mdiv_op_t'(3'd0), 32'h1111_1111, 32'd3);
        check("bad0_state", {31'd0, bus.BUSY, bus.HI, bus.LO}, {32'd0, arch_hi, arch_lo});
        start_op(mdiv_op_t'(3'd7), 32'h2222_2222, 32'd3);
        check("bad7_state", {31'd0, bus.BUSY, bus.HI, bus.LO}, {32'd0, arch_hi, arch_lo});

        for (int i = 0; i < 6; i++) begin
            ra  = $urandom;
            rb  = (i == 3) ? 32'd0 : $urandom >> (i * 4);
            rop = mdiv_op_t'(3'(1 + (i % 4)));
            issue("rand", rop, ra, rb);
            wait_done(33);
        end

        // Asynchronous reset mid-MULT.
        issue("mult_reset", MD_MULT, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (14) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_busy", 64'(bus.BUSY), 64'd0);
        check("areset_hilo", {bus.HI, bus.LO}, 64'd0);
        exp_q.delete();
        arch_hi = '0;
        arch_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        push_const("multu_post_reset", 32'd0, 32'd12);
        start_op(MD_MULTU, 32'd3, 32'd4);
        wait_done(33);

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mdiv_unit.md
Name: mdiv_unit

Overview:
- Iterative multiply/divide unit that owns the HI/LO architectural registers for the MIPS-style pipeline.
- Sits beside the M1 stage and accepts an operation when the instruction is in M.
- Produces the BUSY flag consumed by the hazard unit as MDIV_BUSY_M. The hazard unit stalls MFHI/MFLO in M while BUSY=1.
- Multiply is radix-2 shift-add; divide is restoring. Both run a fixed 32 iterations plus one sign-fixup cycle.

Parameters:
- XLEN, 32, operand width; the iteration count equals XLEN.

Ports:
- CLK  in  1  clock.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  operation request; already qualified by the caller (M stage valid, not stalled, not flushed).
- OP  in  3  mdiv_op_t: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
- SRC_A  in  XLEN  rs value (multiplicand / dividend / MTHI-MTLO data).
- SRC_B  in  XLEN  rt value (multiplier / divisor).
- BUSY  out  1  operation in flight; drives MDIV_BUSY_M.
- HI  out  XLEN  architectural HI register.
- LO  out  XLEN  architectural LO register.

Behaviour:
- Reset (asynchronous, RESET_N=0):
  - state=IDLE, BUSY=0, HI=0, LO=0, counter=0, all working registers cleared.
  - Reset mid-operation abandons the operation; HI/LO read 0 afterwards.
- States: IDLE, RUN, FIX. BUSY = (state != IDLE), taken straight from the state register (no combinational path from START).
- IDLE with START and a mult/div OP:
  - Latch |A| and |B| (absolute values for signed ops, raw values for unsigned ops).
  - Latch neg_q = sA^sB and neg_r = sA; both are 0 for unsigned ops.
  - Load counter = XLEN-1 and go to RUN.
- RUN, multiply:
  - Each cycle: if multiplier LSB=1, add multiplicand into the upper half of the 2*XLEN accumulator; then shift the accumulator right by 1, with the carry entering the MSB.
- RUN, divide:
  - Each cycle: shift {rem,quo} left by 1, trial-subtract the divisor from rem.
  - If non-negative: keep the difference and set quo LSB=1; otherwise restore.
- RUN exit: when counter=0, go to FIX; otherwise decrement the counter.
- FIX:
  - Multiply: if neg_q, negate the 64-bit product (two's complement). {HI,LO} <= product.
  - Divide: LO <= neg_q ? -quo : quo; HI <= neg_r ? -rem : rem.
  - Go to IDLE.
- Latency:
  - START sampled at edge t: RUN occupies cycles t+1..t+32, FIX occupies cycle t+33.
  - HI/LO update at the edge closing t+33; BUSY is 1 for exactly 33 cycles.
  - An MFHI/MFLO in M during cycle t+34 reads the new value.
- HI/LO hold their old values throughout RUN/FIX; intermediate results are never visible.
- MTHI/MTLO:
  - Single-cycle: HI (or LO) <= SRC_A at the sampling edge; BUSY is never asserted.
  - If issued while BUSY, the in-flight operation is aborted (state -> IDLE) and the write takes effect.
- START with a new mult/div while BUSY: the in-flight operation is aborted and the new operation restarts from a fresh operand latch. The full 33-cycle latency applies from the new START.
- Divide by zero (no trap):
  - Unsigned: LO=0xFFFFFFFF, HI=SRC_A.
  - Signed: the divisor counts as non-negative. Quotient magnitude is 0xFFFFFFFF, negated when the dividend is negative (LO=0x00000001). HI=SRC_A.
- Signed overflow 0x80000000 / -1: LO=0x80000000, HI=0. Absolute value of 0x80000000 is taken as unsigned 0x80000000.
- START with OP outside the defined set: ignored, no state change.

Decomposition:
- mdiv_pkg holds:
  - mdiv_op_t enum (3 bits: MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6).
  - mdiv_state_t (IDLE/RUN/FIX).
  - The XLEN default.
- One natural sub-module, mdiv_step: a combinational single-iteration datapath (shift-add step / restore-subtract step selected by an is_div input), instantiated once.

Test Plan:
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> BUSY high exactly 33 cycles; HI=0xFFFFFFFE, LO=0x00000001 visible at cycle t+34.
- MULT A=0xFFFFFFFD(-3) B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; then DIV A=0xFFFFFFF9(-7) B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=100 B=0 -> LO=0xFFFFFFFF, HI=100.
- DIV A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Abort cases:
  - MULTU 5*6 started, new DIVU 100/7 issued at cycle t+10 -> BUSY stays high until 33 cycles after the second START; HI=2, LO=14; no trace of the product 30.
  - MTLO 0x1234 issued mid-DIV -> BUSY drops the next cycle, LO=0x1234, HI unchanged.
- RESET_N pulsed low at cycle t+15 of a MULT -> BUSY=0, HI=LO=0 immediately (asynchronous); a subsequent MULTU 3*4 -> LO=12, HI=0.
